// File: rtl/cordic_sched.sv
// Round-robin scheduler that shares one iterative cordic core between NREQ requesters,
// returning each result tagged with its owner and aborting jobs that exceed TIMEOUT cycles.
//
//   state   | meaning
//   S_IDLE  | waiting for a valid request; grants one requester round-robin
//   S_START | one-cycle start pulse to the core, watchdog cleared
//   S_BUSY  | waiting for core done, watchdog running
//   S_RESP  | result (or timeout error) presented until rsp_ready
module cordic_sched #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_x,
   input  logic [NREQ*32-1:0] req_y,
   input  logic [NREQ*32-1:0] req_z,
   input  logic [NREQ-1:0]    req_mode,
   output logic               cor_start,
   output logic [31:0]        cor_x,
   output logic [31:0]        cor_y,
   output logic [31:0]        cor_z,
   output logic               cor_mode,
   input  logic               cor_done,
   input  logic [31:0]        cor_x_n,
   input  logic [31:0]        cor_y_n,
   input  logic [31:0]        cor_z_n,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [31:0]        rsp_x,
   output logic [31:0]        rsp_y,
   output logic [31:0]        rsp_z,
   output logic               rsp_err,
   output logic               busy,
   output logic               fault
);

   localparam int PW  = $clog2(NREQ);
   localparam int WDW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr;
   logic [WDW-1:0]  wdog;
   logic            grant_vld;
   logic [PW-1:0]   grant_idx;
   logic            grant;
   logic            wdog_exp;

   // Two passes: indices at or above rr_ptr first, then wrap to the low indices.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_vld && req_valid[i] && (PW'(i) >= rr_ptr)) begin
            grant_vld = 1'b1;
            grant_idx = PW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_vld && req_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = PW'(i);
         end
      end
   end

   assign grant    = (state_q == S_IDLE) && !fault && grant_vld;
   assign wdog_exp = (wdog == WDW'(TIMEOUT - 1));

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[grant_idx] = 1'b1;
   end

   assign cor_start = (state_q == S_START);
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant) state_d = S_START;
         S_START: state_d = S_BUSY;
         S_BUSY:  if (cor_done || wdog_exp) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr   <= '0;
         wdog     <= '0;
         cor_x    <= '0;
         cor_y    <= '0;
         cor_z    <= '0;
         cor_mode <= 1'b0;
         rsp_id   <= '0;
         rsp_x    <= '0;
         rsp_y    <= '0;
         rsp_z    <= '0;
         rsp_err  <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (grant) begin
                  cor_x    <= req_x[32*grant_idx +: 32];
                  cor_y    <= req_y[32*grant_idx +: 32];
                  cor_z    <= req_z[32*grant_idx +: 32];
                  cor_mode <= req_mode[grant_idx];
                  rsp_id   <= IDW'(grant_idx);
                  rr_ptr   <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
               end
            end
            S_START: wdog <= '0;
            S_BUSY: begin
               if (wdog != '1) wdog <= wdog + 1'b1;
               // Done takes priority over a coinciding watchdog expiry.
               if (cor_done) begin
                  rsp_x   <= cor_x_n;
                  rsp_y   <= cor_y_n;
                  rsp_z   <= cor_z_n;
                  rsp_err <= 1'b0;
               end else if (wdog_exp) begin
                  rsp_x   <= '0;
                  rsp_y   <= '0;
                  rsp_z   <= '0;
                  rsp_err <= 1'b1;
                  fault   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
